// File: rtl/ps2_device.sv
// PS/2 device-side transceiver: sends bytes to the host and receives host
// commands, generating the PS/2 clock itself and driving both lines open-drain.
module ps2_device #(
    parameter int HALF_PERIOD = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2CLK_in,
    input  logic       PS2DATA_in,
    output logic       PS2CLK_oe,
    output logic       PS2DATA_oe,
    input  logic [7:0] datain,
    input  logic       tx_write,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] dataout,
    output logic       rx_done,
    output logic       rx_err,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    // Handshake: tx_write is a one-cycle request taken only in IDLE with the
    // bus free; tx_done/tx_err/rx_done are one-cycle pulses, rx_err valid with rx_done.

    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_HI   = 3'd1,
        TX_LO   = 3'd2,
        RX_WAIT = 3'd3,
        RX_LO   = 3'd4,
        RX_HI   = 3'd5,
        ACK_LO  = 3'd6,
        ACK_HI  = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_q, bit_d;
    logic [10:0]     frame_q, frame_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_par_q, rx_par_d;
    logic [7:0]      dataout_q, dataout_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_err_q, tx_err_d;
    logic            rx_done_q, rx_done_d;
    logic            rx_err_q, rx_err_d;
    logic            clk_s1_q, clk_s_q;
    logic            dat_s1_q, dat_s_q;
    logic            clk_oe, dat_oe;
    logic            rts, last;

    assign rts  = ~dat_s_q & clk_s_q;
    assign last = (timer_q == TW'(HALF_PERIOD - 1));

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        rx_data_d = rx_data_q;
        rx_par_d  = rx_par_q;
        dataout_d = dataout_q;
        tx_done_d = 1'b0;
        tx_err_d  = 1'b0;
        rx_done_d = 1'b0;
        rx_err_d  = 1'b0;
        clk_oe    = 1'b0;
        dat_oe    = 1'b0;
        case (state_q)
            IDLE: begin
                // A host request-to-send always wins over a local transmit.
                if (rts) begin
                    state_d = RX_WAIT;
                end else if (tx_write && clk_s_q) begin
                    frame_d = {1'b1, ~^datain, datain, 1'b0};
                    bit_d   = 4'd0;
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                dat_oe = ~frame_q[bit_q];
                if (last) begin
                    if (!clk_s_q) begin
                        tx_err_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = TX_LO;
                    end
                end
            end
            TX_LO: begin
                clk_oe = 1'b1;
                dat_oe = ~frame_q[bit_q];
                if (last) begin
                    if (bit_q == 4'd10) begin
                        tx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = TX_HI;
                    end
                end
            end
            RX_WAIT: begin
                if (!rts) begin
                    state_d = IDLE;
                end else if (last) begin
                    bit_d   = 4'd0;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                clk_oe = 1'b1;
                if (last) state_d = RX_HI;
            end
            RX_HI: begin
                if (last) begin
                    if (!clk_s_q) begin
                        state_d = IDLE;
                    end else if (bit_q < 4'd8) begin
                        rx_data_d[bit_q[2:0]] = dat_s_q;
                        bit_d   = bit_q + 4'd1;
                        state_d = RX_LO;
                    end else if (bit_q == 4'd8) begin
                        rx_par_d = dat_s_q;
                        bit_d    = bit_q + 4'd1;
                        state_d  = RX_LO;
                    end else if (dat_s_q) begin
                        state_d = ACK_LO;
                    end else begin
                        // Framing error: no ACK, report immediately.
                        dataout_d = rx_data_q;
                        rx_done_d = 1'b1;
                        rx_err_d  = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            ACK_LO: begin
                clk_oe = 1'b1;
                dat_oe = 1'b1;
                if (last) state_d = ACK_HI;
            end
            ACK_HI: begin
                dat_oe = 1'b1;
                if (last) begin
                    dataout_d = rx_data_q;
                    rx_done_d = 1'b1;
                    rx_err_d  = ~^{rx_data_q, rx_par_q};
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= 4'd0;
            frame_q   <= 11'd0;
            rx_data_q <= 8'h00;
            rx_par_q  <= 1'b0;
            dataout_q <= 8'h00;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
            clk_s1_q  <= 1'b1;
            clk_s_q   <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            rx_data_q <= rx_data_d;
            rx_par_q  <= rx_par_d;
            dataout_q <= dataout_d;
            tx_done_q <= tx_done_d;
            tx_err_q  <= tx_err_d;
            rx_done_q <= rx_done_d;
            rx_err_q  <= rx_err_d;
            clk_s1_q  <= PS2CLK_in;
            clk_s_q   <= clk_s1_q;
            dat_s1_q  <= PS2DATA_in;
            dat_s_q   <= dat_s1_q;
        end
    end

    assign PS2CLK_oe   = clk_oe;
    assign PS2DATA_oe  = dat_oe;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;
    assign rx_done     = rx_done_q;
    assign rx_err      = rx_err_q;
    assign dataout     = dataout_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device with HALF_PERIOD=4: a host model drives the
// open-drain bus while the device transmits, receives, is inhibited or reset.
module tb_ps2_device;

    localparam int HP = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       tx_write = 1'b0;
    logic       PS2CLK_in, PS2DATA_in, PS2CLK_oe, PS2DATA_oe;
    logic       tx_done, tx_err, rx_done, rx_err, busy;
    logic [7:0] dataout;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;
    int n_txd = 0;
    int n_txe = 0;
    int n_rxd = 0;

    assign PS2CLK_in  = ~(PS2CLK_oe | host_clk_low);
    assign PS2DATA_in = ~(PS2DATA_oe | host_dat_low);

    ps2_device #(.HALF_PERIOD(HP)) dut (
        .CLK(CLK), .RST(RST),
        .PS2CLK_in(PS2CLK_in), .PS2DATA_in(PS2DATA_in),
        .PS2CLK_oe(PS2CLK_oe), .PS2DATA_oe(PS2DATA_oe),
        .datain(datain), .tx_write(tx_write),
        .tx_done(tx_done), .tx_err(tx_err),
        .dataout(dataout), .rx_done(rx_done), .rx_err(rx_err),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (tx_done) n_txd++;
        if (tx_err)  n_txe++;
        if (rx_done) n_rxd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 clk_oe=1, 1 clk_oe=0, 2 data_oe=1, 3 tx_err=1
    task automatic wait_sig(input int which, input string tag);
        logic ok;
        int   k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 200) begin
            @(negedge CLK);
            k++;
            case (which)
                0: ok = (PS2CLK_oe === 1'b1);
                1: ok = (PS2CLK_oe === 1'b0);
                2: ok = (PS2DATA_oe === 1'b1);
                default: ok = (tx_err === 1'b1);
            endcase
        end
        check({tag, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic host_send(input logic [7:0] d, input logic par, input logic stp,
                             input logic txw_rts, input int txw_bit, input int rst_bit);
        logic [9:0] bits;
        bits = {stp, par, d};
        @(posedge CLK); #1 host_dat_low = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1 if (txw_rts) tx_write = 1'b1;
        @(posedge CLK); #1 tx_write = 1'b0;
        for (int b = 0; b < 10; b++) begin
            wait_sig(0, "rx_clk_low");
            if (b == rst_bit) return;
            host_dat_low = ~bits[b];
            if (b == txw_bit) begin
                tx_write = 1'b1;
                @(posedge CLK); #1 tx_write = 1'b0;
            end
            wait_sig(1, "rx_clk_high");
        end
        host_dat_low = 1'b0;
    endtask

    task automatic rx_finish(input logic [7:0] exp_data, input logic exp_err, input string tag);
        int ack_cyc, ack_clk;
        ack_cyc = 0;
        ack_clk = 0;
        wait_sig(2, {tag, "_ack"});
        while (PS2DATA_oe === 1'b1 && ack_cyc < 50) begin
            ack_cyc++;
            if (PS2CLK_oe === 1'b1) ack_clk++;
            @(negedge CLK);
        end
        check({tag, "_ack_data_cycles"}, ack_cyc, 2 * HP);
        check({tag, "_ack_clk_cycles"}, ack_clk, HP);
        check({tag, "_rx_done"}, {31'd0, rx_done}, 32'd1);
        check({tag, "_dataout"}, {24'd0, dataout}, {24'd0, exp_data});
        check({tag, "_rx_err"}, {31'd0, rx_err}, {31'd0, exp_err});
        repeat (20) @(negedge CLK);
    endtask

    initial begin
        logic [10:0] exp_frame;
        logic [10:0] got;
        int          bi, done_at, nf, snap_txd, snap_txe, snap_rxd;
        logic        prev;

        // reset
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_clk_oe", {31'd0, PS2CLK_oe}, 32'd0);
        check("rst_dat_oe", {31'd0, PS2DATA_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {28'd0, tx_done, tx_err, rx_done, rx_err}, 32'd0);
        check("rst_dataout", {24'd0, dataout}, 32'h00);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        repeat (5) @(posedge CLK);

        // transmit 8'hFA: bus levels start,0,1,0,1,1,1,1,1,parity=1,stop=1
        exp_frame = 11'b11_11111010_0;
        got = '0; bi = 0; done_at = -1; prev = 1'b0;
        snap_txe = n_txe;
        #1 datain = 8'hFA; tx_write = 1'b1;
        @(posedge CLK); #1 tx_write = 1'b0;
        for (int n = 0; n < 120; n++) begin
            @(negedge CLK);
            if (n == 0) check("tx_busy", {31'd0, busy}, 32'd1);
            if (PS2CLK_oe && !prev && bi < 11) begin
                got[bi] = ~PS2DATA_oe;
                bi++;
            end
            prev = PS2CLK_oe;
            if (tx_done && done_at < 0) done_at = n;
        end
        check("tx_bit_count", bi, 11);
        for (int i = 0; i < 11; i++) check($sformatf("tx_bit%0d", i), {31'd0, got[i]}, {31'd0, exp_frame[i]});
        check("tx_done_latency", done_at, 22 * HP);
        check("tx_no_err", n_txe, snap_txe);
        check("tx_end_busy", {31'd0, busy}, 32'd0);

        // transmit with host inhibit during bit 4 TX_HI
        snap_txd = n_txd; snap_txe = n_txe;
        @(posedge CLK); #1 datain = 8'h5A; tx_write = 1'b1;
        @(posedge CLK); #1 tx_write = 1'b0;
        nf = 0; prev = 1'b0;
        for (int n = 0; n < 200 && nf < 4; n++) begin
            @(negedge CLK);
            if (prev && !PS2CLK_oe) nf++;
            prev = PS2CLK_oe;
        end
        check("inh_falls", nf, 4);
        host_clk_low = 1'b1;
        wait_sig(3, "inh_tx_err");
        check("inh_clk_oe", {31'd0, PS2CLK_oe}, 32'd0);
        check("inh_dat_oe", {31'd0, PS2DATA_oe}, 32'd0);
        check("inh_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge CLK);
        host_clk_low = 1'b0;
        repeat (20) @(negedge CLK);
        check("inh_no_done", n_txd, snap_txd);
        check("inh_err_count", n_txe, snap_txe + 1);

        // receive 8'hF4, odd parity correct (0)
        host_send(8'hF4, 1'b0, 1'b1, 1'b0, -1, -1);
        rx_finish(8'hF4, 1'b0, "rx_ok");

        // receive 8'hF4 with wrong parity
        host_send(8'hF4, 1'b1, 1'b1, 1'b0, -1, -1);
        rx_finish(8'hF4, 1'b1, "rx_par");

        // tx_write coinciding with RTS, then again while busy
        snap_txd = n_txd; snap_txe = n_txe;
        datain = 8'h3C;
        host_send(8'hF4, 1'b0, 1'b1, 1'b1, 2, -1);
        rx_finish(8'hF4, 1'b0, "rx_col");
        repeat (30) @(negedge CLK);
        check("col_no_tx_done", n_txd, snap_txd);
        check("col_no_tx_err", n_txe, snap_txe);
        check("col_idle", {31'd0, busy}, 32'd0);

        // reset during receive of data bit 5
        host_send(8'hF4, 1'b0, 1'b1, 1'b0, -1, 5);
        snap_rxd = n_rxd;
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0; host_dat_low = 1'b0;
        @(negedge CLK);
        check("mrst_clk_oe", {31'd0, PS2CLK_oe}, 32'd0);
        check("mrst_dat_oe", {31'd0, PS2DATA_oe}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_dataout", {24'd0, dataout}, 32'h00);
        repeat (30) @(negedge CLK);
        check("mrst_no_rx_done", n_rxd, snap_rxd);
        check("mrst_still_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_device.md
PS2_DEVICE -- requirements
Module: ps2_device

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 1000: CLK cycles per PS/2 clock phase (low or high).
REQ-002 SHALL have port CLK  input  1  system clock; every register updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports PS2CLK_in, PS2DATA_in  input  1 each  sensed PS/2 bus levels.
REQ-005 SHALL have ports PS2CLK_oe, PS2DATA_oe  output  1 each  1 = drive the line low, 0 = release it (open-drain).
REQ-006 SHALL have port datain  input  8  byte to send to the host.
REQ-007 SHALL have port tx_write  input  1  single-cycle request to send datain.
REQ-008 SHALL have ports tx_done, tx_err  output  1 each  one-cycle pulses: frame completed / frame aborted.
REQ-009 SHALL have port dataout  output  8  last byte received from the host.
REQ-010 SHALL have ports rx_done, rx_err  output  1 each  one-cycle pulse on receive completion; rx_err is valid only with rx_done.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass PS2CLK_in and PS2DATA_in through 2-FF synchronizers; all bus decisions SHALL use the synchronized values.
REQ-013 SHALL implement the FSM states IDLE, TX_HI, TX_LO, RX_WAIT, RX_LO, RX_HI, ACK_LO, ACK_HI.
REQ-014 SHALL use a phase timer that counts HALF_PERIOD cycles per state visit, and a 4-bit bit index.
REQ-015 IDLE SHALL hold PS2CLK_oe=0 and PS2DATA_oe=0.
REQ-016 IDLE SHALL enter RX_WAIT when synchronized data=0 and clock=1.
REQ-017 RX_WAIT SHALL return to IDLE if that condition breaks before HALF_PERIOD consecutive cycles.
REQ-018 IDLE SHALL accept tx_write only when the synchronized clock=1 and no RX request is present.
REQ-019 On accept, the block SHALL latch the frame {stop=1, odd parity, datain[7:0] LSB-first, start=0} and enter TX_HI with bit index 0.
REQ-020 A tx_write that arrives while busy, while the clock is inhibited, or in the same cycle as an RX request SHALL be ignored: no tx_done and no tx_err.
REQ-021 TX_HI SHALL release the clock and drive PS2DATA_oe = ~frame[bit] for HALF_PERIOD cycles; data SHALL change only on entry to TX_HI.
REQ-022 TX_LO SHALL assert PS2CLK_oe for HALF_PERIOD cycles, holding data unchanged.
REQ-023 After bit 10's TX_LO, the block SHALL release both lines, pulse tx_done, and return to IDLE.
REQ-024 A transmit frame SHALL last exactly 22*HALF_PERIOD cycles from accept to tx_done.
REQ-025 Host inhibit during transmit: if the synchronized clock=0 at the last cycle of any TX_HI, the block SHALL release both lines, pulse tx_err, and return to IDLE.
REQ-026 Receive clocking: RX_LO SHALL drive the clock low for HALF_PERIOD cycles, then RX_HI SHALL release it for HALF_PERIOD cycles.
REQ-027 Receive sampling: data SHALL be sampled at the last cycle of each RX_HI; 10 bits total (8 data LSB-first, parity, stop).
REQ-028 Host inhibit during receive: a clock=0 sample at the end of any RX_HI SHALL abort to IDLE with no rx_done.
REQ-029 If stop=1, the block SHALL enter ACK_LO: PS2DATA_oe=1 and PS2CLK_oe=1 for HALF_PERIOD cycles.
REQ-030 ACK_HI SHALL release the clock with data still low for HALF_PERIOD cycles, then release data.
REQ-031 After ACK_HI, the block SHALL pulse rx_done with dataout updated in the same cycle.
REQ-032 rx_err SHALL be 1 iff parity is not odd.
REQ-033 If stop=0, the block SHALL skip ACK, update dataout, and pulse rx_done with rx_err=1 immediately after the stop sample.
REQ-034 dataout SHALL hold its value until the next rx_done.

Reset
REQ-035 While RST=1 at a rising CLK edge, the FSM SHALL go to IDLE, and the timer and bit index SHALL clear.
REQ-036 On reset, PS2CLK_oe, PS2DATA_oe, tx_done, tx_err, rx_done, rx_err and busy SHALL go to 0, and dataout SHALL go to 8'h00.
REQ-037 Reset mid-frame SHALL release both lines on the next cycle with no done or err pulse.

Verification (HALF_PERIOD=4)
REQ-038 SHALL cover: datain=8'hFA, tx_write pulse in idle -> PS2DATA_oe pattern (inverted) over bits = 0,0,1,0,1,1,1,1,1,1(parity),1(stop); tx_done exactly 88 cycles after accept.
REQ-039 SHALL cover: host RTS (data low, clock high), then host drives 8'hF4 with parity=0, stop=1 on device clocks -> ACK low for one clock; rx_done with dataout=8'hF4, rx_err=0.
REQ-040 SHALL cover: host sends 8'hF4 with parity=1 -> rx_done with rx_err=1, dataout=8'hF4, ACK still issued.
REQ-041 SHALL cover: host holds the clock low during bit 4's TX_HI of a transmit -> tx_err pulse, both oe=0, busy=0, no tx_done.
REQ-042 SHALL cover: tx_write in the same cycle the RTS condition appears -> receive proceeds, no tx_done/tx_err; a later tx_write while busy is also ignored.
REQ-043 SHALL cover: RST=1 during RX bit 5 -> next cycle both oe=0, busy=0, dataout=8'h00, no rx_done.
